// File: rtl/fir_acc_pkg.sv
// Shared constants and types for the FIR accelerator result path.
// Holds the result width, FIFO depth, APB register map and FIFO status layout.
package fir_acc_pkg;

    localparam int unsigned FIR_IW     = 12;
    localparam int unsigned FIR_OW     = 2 * FIR_IW + 7;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);

    // APB byte offsets of the result FIFO registers
    localparam logic [7:0] FIFO_DATA_OFFSET   = 8'h20;
    localparam logic [7:0] FIFO_STATUS_OFFSET = 8'h24;
    localparam logic [7:0] FIFO_THRESH_OFFSET = 8'h28;

    typedef struct packed {
        logic               overflow;
        logic               underflow;
        logic               full;
        logic               empty;
        logic [FIFO_AW:0]   count;
    } fifo_status_t;

endpackage

// File: rtl/fir_fifo_mem.sv
// DEPTH x DW register array for the result FIFO.
// One synchronous write port and one asynchronous read port; no reset on the storage.
module fir_fifo_mem #(
    parameter int unsigned DW    = 31,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          HCLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge HCLK) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/fir_result_fifo.sv
// First-word-fall-through FIFO that buffers FIR results for APB draining.
// Tracks level, sticky overflow/underflow and a level-threshold interrupt.
module fir_result_fifo
    import fir_acc_pkg::*;
#(
    parameter  int unsigned DW    = FIR_OW,
    parameter  int unsigned DEPTH = FIFO_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          i_valid,
    input  logic [DW-1:0] i_result,
    input  logic          i_pop,
    input  logic          i_flush,
    input  logic          i_clr_flags,
    input  logic [AW:0]   i_thresh,
    output logic [DW-1:0] o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_count,
    output logic          o_overflow,
    output logic          o_underflow,
    output logic          o_irq
);

    localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic          empty, full;
    logic          push_acc, pop_acc;
    logic          ovf_set, unf_set;
    logic [DW-1:0] rdata;

    // A pop on a full FIFO frees the slot the concurrent push lands in.
    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == FullCount);
        push_acc = i_valid && (!full || i_pop) && !i_flush;
        pop_acc  = i_pop && !empty && !i_flush;
        ovf_set  = i_valid && full && !i_pop && !i_flush;
        unf_set  = i_pop && empty && !i_flush;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_acc, pop_acc})
                2'b10:   count_d = count_q + (AW + 1)'(1);
                2'b01:   count_d = count_q - (AW + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Set wins over a coincident clear.
    always_comb begin
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (i_clr_flags) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (ovf_set) begin
            overflow_d = 1'b1;
        end
        if (unf_set) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    fir_fifo_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .HCLK  (HCLK),
        .we    (push_acc),
        .waddr (wr_ptr_q),
        .wdata (i_result),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign o_data      = empty ? '0 : rdata;
    assign o_empty     = empty;
    assign o_full      = full;
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;
    assign o_irq       = (i_thresh != '0) && (count_q >= i_thresh);

endmodule

// File: tb/tb_fir_result_fifo.sv
// Scoreboard bench for fir_result_fifo: queue-based reference model plus a pop monitor.
module tb_fir_result_fifo;
    import fir_acc_pkg::*;

    localparam int unsigned DW    = FIR_OW;
    localparam int unsigned DEPTH = FIFO_DEPTH;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          HCLK;
    logic          HRESETn;
    logic          i_valid;
    logic [DW-1:0] i_result;
    logic          i_pop;
    logic          i_flush;
    logic          i_clr_flags;
    logic [AW:0]   i_thresh;
    logic [DW-1:0] o_data;
    logic          o_empty;
    logic          o_full;
    logic [AW:0]   o_count;
    logic          o_overflow;
    logic          o_underflow;
    logic          o_irq;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] mdl_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf;
    bit            m_unf;

    fir_result_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .i_valid     (i_valid),
        .i_result    (i_result),
        .i_pop       (i_pop),
        .i_flush     (i_flush),
        .i_clr_flags (i_clr_flags),
        .i_thresh    (i_thresh),
        .o_data      (o_data),
        .o_empty     (o_empty),
        .o_full      (o_full),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow),
        .o_irq       (o_irq)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [31:0] exp_data;
        bit exp_irq;
        n = mdl_q.size();
        exp_data = (n == 0) ? 32'd0 : 32'(mdl_q[0]);
        exp_irq  = (i_thresh != 0) && (n >= int'(i_thresh));
        chk({tag, ".count"},     32'(o_count),     32'(n));
        chk({tag, ".empty"},     32'(o_empty),     32'(n == 0));
        chk({tag, ".full"},      32'(o_full),      32'(n == DEPTH));
        chk({tag, ".overflow"},  32'(o_overflow),  32'(m_ovf));
        chk({tag, ".underflow"}, 32'(o_underflow), 32'(m_unf));
        chk({tag, ".irq"},       32'(o_irq),       32'(exp_irq));
        chk({tag, ".data"},      32'(o_data),      exp_data);
    endtask

    // Drive one cycle at posedge+1, advance the model on the edge, check at posedge+1.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit p, input bit f,
                        input bit c, input string tag);
        int n;
        bit mfull, mempty, oset, uset;
        i_valid = v; i_result = d; i_pop = p; i_flush = f; i_clr_flags = c;
        @(posedge HCLK);
        n = mdl_q.size();
        mfull = (n == DEPTH);
        mempty = (n == 0);
        oset = 1'b0;
        uset = 1'b0;
        if (f) begin
            mdl_q.delete();
            exp_q.delete();
        end else begin
            if (p && !mempty) void'(mdl_q.pop_front());
            if (v && (!mfull || p)) begin
                mdl_q.push_back(d);
                exp_q.push_back(d);
            end
            oset = v && mfull && !p;
            uset = p && mempty;
        end
        m_ovf = oset ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = uset ? 1'b1 : (c ? 1'b0 : m_unf);
        #1;
        i_valid = 0; i_pop = 0; i_flush = 0; i_clr_flags = 0;
        check_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        HRESETn = 1'b0;
        #2;
        mdl_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check_all(tag);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
    endtask

    // Monitor: every accepted pop must present the oldest outstanding result.
    initial begin
        forever begin
            @(negedge HCLK);
            if (HRESETn && i_pop && !i_flush && !o_empty) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_pop: got %0h, required no entry (queue empty)", o_data);
                end else begin
                    chk("sb_pop", 32'(o_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        HRESETn = 1'b1;
        i_valid = 0; i_result = '0; i_pop = 0; i_flush = 0; i_clr_flags = 0;
        i_thresh = '0;
        m_ovf = 0; m_unf = 0;
        #2;
        apply_reset("por");

        i_thresh = 3;
        for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0, 0, "fill");
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0, "drain");

        for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0, 0, "refill");
        step(1, 31'h7FFFFFFF, 0, 0, 0, "ovf");
        step(1, 31'h0000055, 1, 0, 0, "full_pp");
        for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0, "drain2");

        step(0, '0, 1, 0, 0, "unf");
        step(0, '0, 0, 0, 1, "clr");
        step(0, '0, 1, 0, 1, "clr_vs_unf");
        step(1, 31'h0000123, 1, 0, 0, "pp_empty");
        step(0, '0, 1, 0, 1, "pop_clr");

        i_thresh = 3;
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)), 0, 0, "wrap");
        end
        i_thresh = 0;
        for (int i = 0; i < 4; i++) step(1, DW'($urandom), 0, 0, 0, "thresh0");

        step(0, '0, 0, 1, 0, "pre_flush");
        for (int i = 0; i < 9; i++) step(1, DW'(32'h100 + i), 0, 0, 0, "fill_ovf");
        step(0, '0, 1, 0, 0, "to7");
        step(0, '0, 1, 0, 0, "to6");
        step(1, 31'h0000ABC, 0, 1, 0, "flush");
        step(1, 31'h0000777, 0, 0, 0, "post_flush");

        for (int i = 0; i < 4; i++) step(1, DW'(32'h200 + i), 0, 0, 0, "pre_rst");
        apply_reset("mid_rst");

        for (int i = 0; i < 400; i++) begin
            bit f, p;
            f = ($urandom_range(0, 19) == 0);
            p = f ? 1'b0 : 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) i_thresh = (AW + 1)'($urandom_range(0, DEPTH));
            step(1'($urandom_range(0, 1)), DW'($urandom), p, f,
                 ($urandom_range(0, 9) == 0), "soak");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
